// File: rtl/mem_rd_scheduler_if.sv
// Bus bundle between the read scheduler and its requesters / memory port.
//   master : scheduler side (drives grants, memory address, return strobes,
//            outstanding count and the sticky tag error)
//   slave  : requester / memory side
//   req_vld/req_addr/req_gnt        per-requester request handshake
//   sch2mem_r_addr/_vld, mem2sch_r_rdy  address channel to memory
//   mem2sch_data/_en                 in-order read return from memory
//   sch2req_data/_en                 return broadcast + one-hot strobe
//   outstanding, tag_err             status
interface mem_rd_scheduler_if #(
  parameter int nReq       = 4,
  parameter int rAddrWidth = 28,
  parameter int rDataWidth = 64,
  parameter int MaxOut     = 4
);
  localparam int CntW = $clog2(MaxOut) + 1;

  logic [nReq-1:0]            req_vld;
  logic [nReq*rAddrWidth-1:0] req_addr;
  logic [nReq-1:0]            req_gnt;
  logic [rAddrWidth-1:0]      sch2mem_r_addr;
  logic                       sch2mem_r_vld;
  logic                       mem2sch_r_rdy;
  logic [rDataWidth-1:0]      mem2sch_data;
  logic                       mem2sch_data_en;
  logic [rDataWidth-1:0]      sch2req_data;
  logic [nReq-1:0]            sch2req_data_en;
  logic [CntW-1:0]            outstanding;
  logic                       tag_err;

  modport master (
    input  req_vld, req_addr, mem2sch_r_rdy, mem2sch_data, mem2sch_data_en,
    output req_gnt, sch2mem_r_addr, sch2mem_r_vld, sch2req_data,
           sch2req_data_en, outstanding, tag_err
  );

  modport slave (
    output req_vld, req_addr, mem2sch_r_rdy, mem2sch_data, mem2sch_data_en,
    input  req_gnt, sch2mem_r_addr, sch2mem_r_vld, sch2req_data,
           sch2req_data_en, outstanding, tag_err
  );
endinterface

// File: rtl/mem_rd_scheduler.sv
// Round-robin read scheduler: arbitrates nReq requesters onto one memory
// read address channel, tracks up to MaxOut in-flight reads in an in-order
// tag FIFO and steers each return strobe back to the requester that issued it.
// Ports:
//   clk_bus : bus clock, rising-edge
//   rst_bus : asynchronous active-high reset
//   bus     : mem_rd_scheduler_if.master (request, memory and return signals)
module mem_rd_scheduler #(
  parameter int nReq       = 4,
  parameter int rAddrWidth = 28,
  parameter int rDataWidth = 64,
  parameter int MaxOut     = 4
) (
  input  logic                clk_bus,
  input  logic                rst_bus,
  mem_rd_scheduler_if.master  bus
);
  localparam int IdxW = $clog2(nReq);
  localparam int PtrW = $clog2(MaxOut);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOut);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(nReq - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, FULL} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IdxW-1:0]       r_last_gnt;
  logic [rAddrWidth-1:0] r_addr;
  logic [IdxW-1:0]       r_tags [MaxOut];
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [CntW-1:0]       r_outstanding;
  logic                  r_tag_err;

  logic [IdxW-1:0]       w_cand;
  logic [IdxW-1:0]       w_sel;
  logic                  w_found;
  logic                  w_full;
  logic                  w_grant;
  logic                  w_push;
  logic                  w_ret;
  logic                  w_spurious;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= nReq; k++) begin
      w_cand = IdxW'((32'(r_last_gnt) + k) % nReq);
      if (!w_found && bus.req_vld[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  assign w_full     = (r_outstanding == MaxCnt);
  // Gated by reset so the combinational grant is quiet while reset is held.
  assign w_grant    = (r_state == IDLE) && !w_full && w_found && !rst_bus;
  assign w_push     = (r_state == ISSUE) && bus.mem2sch_r_rdy;
  assign w_ret      = bus.mem2sch_data_en && (r_outstanding != '0);
  assign w_spurious = bus.mem2sch_data_en && (r_outstanding == '0);

  always_comb begin
    w_state_nxt         = r_state;
    bus.req_gnt         = '0;
    bus.sch2mem_r_vld   = 1'b0;
    bus.sch2req_data_en = '0;
    case (r_state)
      IDLE: begin
        if (w_full) begin
          w_state_nxt = FULL;
        end else if (w_grant) begin
          w_state_nxt          = ISSUE;
          bus.req_gnt[w_sel]   = 1'b1;
        end
      end
      ISSUE: begin
        bus.sch2mem_r_vld = 1'b1;
        if (bus.mem2sch_r_rdy) w_state_nxt = IDLE;
      end
      FULL: begin
        if (!w_full) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_ret) bus.sch2req_data_en[r_tags[r_rd_ptr]] = 1'b1;
  end

  always_ff @(posedge clk_bus or posedge rst_bus) begin
    if (rst_bus) begin
      r_state       <= IDLE;
      r_last_gnt    <= LastIdx;
      r_addr        <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_outstanding <= '0;
      r_tag_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_addr     <= bus.req_addr[w_sel*rAddrWidth +: rAddrWidth];
        r_last_gnt <= w_sel;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_ret)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_ret) begin
        r_outstanding <= r_outstanding + 1'b1;
      end else if (!w_push && w_ret) begin
        r_outstanding <= r_outstanding - 1'b1;
      end
      if (w_spurious) r_tag_err <= 1'b1;
    end
  end

  // Tag storage needs no reset: the pointers define what is valid.
  // last_gnt still holds the issuing requester while in ISSUE.
  always_ff @(posedge clk_bus) begin
    if (w_push) r_tags[r_wr_ptr] <= r_last_gnt;
  end

  assign bus.sch2req_data   = bus.mem2sch_data;
  assign bus.sch2mem_r_addr = r_addr;
  assign bus.outstanding    = r_outstanding;
  assign bus.tag_err        = r_tag_err;
endmodule

// File: doc/mem_rd_scheduler.md
MEM_RD_SCHEDULER -- requirements
Module: mem_rd_scheduler

Interface
REQ-001 SHALL have parameter nReq, default 4: number of read requesters (2..8).
REQ-002 SHALL have parameter rAddrWidth, default 28: read address width.
REQ-003 SHALL have parameter rDataWidth, default 64: read data width.
REQ-004 SHALL have parameter MaxOut, default 4: maximum outstanding reads (power of 2, 2..16).
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with these ports (name, direction, width, meaning):
- clk_bus  in  1: bus clock; all state changes on its rising edge.
- rst_bus  in  1: asynchronous, active-high reset.
- req_vld  in  nReq: per-requester read request valid.
- req_addr  in  nReq*rAddrWidth: per-requester address; slice i belongs to requester i.
- req_gnt  out  nReq: one-hot, one-cycle grant; requester i drops or advances its request after it.
- sch2mem_r_addr  out  rAddrWidth: address to the memory interface.
- sch2mem_r_vld  out  1: address valid to the memory interface.
- mem2sch_r_rdy  in  1: memory interface accepts the address.
- mem2sch_data  in  rDataWidth: read return data.
- mem2sch_data_en  in  1: read return valid, in issue order.
- sch2req_data  out  rDataWidth: return data broadcast to all requesters.
- sch2req_data_en  out  nReq: one-hot return strobe.
- outstanding  out  $clog2(MaxOut)+1: count of issued, unreturned reads.
- tag_err  out  1: sticky; set when a return arrives with nothing outstanding.

Function
REQ-006 SHALL implement the FSM states IDLE, ISSUE and FULL.
REQ-007 IDLE, some req_vld bit set, outstanding<MaxOut: SHALL select requester i by round-robin, searching from last_gnt+1 and wrapping past nReq-1 to 0.
REQ-008 In the cycle of that selection, req_gnt[i] SHALL be 1 (combinational in IDLE). On the edge, the FSM SHALL capture req_addr slice i into the address register and i into last_gnt, then go to ISSUE.
REQ-009 IDLE with outstanding==MaxOut SHALL go to FULL, with no grant issued.
REQ-010 ISSUE: sch2mem_r_vld SHALL be 1, and sch2mem_r_addr SHALL be stable until mem2sch_r_rdy==1.
REQ-011 On the ISSUE handshake edge, the FSM SHALL push tag i into the in-order tag FIFO (depth MaxOut), increment outstanding and return to IDLE. Peak issue rate is one read per 2 cycles.
REQ-012 FULL SHALL return to IDLE on the first edge where outstanding<MaxOut.
REQ-013 On mem2sch_data_en==1 with outstanding>0: sch2req_data_en[head tag] SHALL be 1 in the same cycle; the tag FIFO SHALL pop and outstanding SHALL decrement on the edge.
REQ-014 sch2req_data SHALL equal mem2sch_data combinationally at all times.
REQ-015 On mem2sch_data_en==1 with outstanding==0: sch2req_data_en SHALL stay all-zero, tag_err SHALL be set to 1 and hold until reset, and outstanding SHALL stay 0 (no underflow).
REQ-016 A handshake and a return in the same cycle SHALL push and pop together, leaving outstanding unchanged. A return in FULL SHALL be honoured normally.
REQ-017 The tag FIFO pointers SHALL wrap modulo MaxOut. outstanding SHALL never exceed MaxOut.
REQ-018 The FSM SHALL never grant while in ISSUE or FULL. Requests that are not granted SHALL wait without loss.
REQ-019 req_gnt SHALL have at most one bit set, and sch2req_data_en SHALL have at most one bit set.

Reset
REQ-020 While rst_bus==1, independent of the clock: state=IDLE, last_gnt=nReq-1, outstanding=0, tag FIFO empty, tag_err=0, sch2mem_r_vld=0, sch2mem_r_addr=0, req_gnt=0, sch2req_data_en=0.
REQ-021 Reset in mid-operation SHALL discard all pending tags. Returns that arrive after reset SHALL set tag_err.
REQ-022 The first grant after reset SHALL go to requester 0 when req_vld[0]==1.

Verification
REQ-023 Single read: req_vld=4'b0100, addr2=0x0000ABC, mem rdy=1 -> req_gnt=4'b0100 at cycle 0; cycle 1 vld=1, addr=0x0000ABC; outstanding=1; a return strobe gives sch2req_data_en=4'b0100.
REQ-024 Round-robin: req_vld=4'b1111 held, rdy=1, returns fast -> grant order 0,1,2,3,0,...
REQ-025 Back-pressure: rdy=0 for 5 cycles -> vld=1 and addr stable for 5 cycles, no grants, then issue on the rdy cycle.
REQ-026 Saturation: MaxOut=4, no returns -> 4 issues, outstanding=4, FSM in FULL, req_gnt=0. One return -> outstanding=3, then the next grant.
REQ-027 Same-cycle handshake plus return with outstanding=2 -> outstanding stays 2, and return order matches issue order.
REQ-028 Spurious return at outstanding=0 -> tag_err=1, sch2req_data_en=0. Then assert rst_bus mid-ISSUE -> all outputs at reset values immediately.
